cp0_regs: RTL and testbench

Coprocessor-0 register bank sitting directly downstream of the exception handler in the MIPS core. It captures the handler's `Except`/`cause`/`badpc`/`badAddress`/`state` outputs into architectural CP0 registers and produces a one-cycle PC redirect to the exception vector or, on `eret`, to EPC. It serves `mtc0`/`mfc0` and runs the Count/Compare timer. The timer drives the `Int` line back into the handler.

---
 rtl/cp0_pkg.sv | 41 ++++
 rtl/cp0_timer.sv | 48 ++++
 rtl/cp0_regs.sv | 113 +++++++++++
 tb/tb_cp0_regs.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// CP0 register numbers, bit positions, exception codes and write masks
// shared by the coprocessor-0 register bank and its timer.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam int ST_IE     = 0;
    localparam int ST_EXL    = 1;
    localparam int ST_IM_LO  = 8;
    localparam int ST_IM_HI  = 15;
    localparam int ST_BEV    = 22;

    localparam int CA_BD     = 31;
    localparam int CA_TI     = 30;
    localparam int CA_IP_LO  = 8;
    localparam int CA_IP_HI  = 15;
    localparam int CA_EXC_LO = 2;
    localparam int CA_EXC_HI = 6;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_SYS  = 5'd8;
    localparam logic [4:0] EXC_BP   = 5'd9;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    function automatic logic is_addr_exc(input logic [4:0] code);
        return (code == EXC_ADEL) || (code == EXC_ADES);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer: Count advances every second cycle, TI is sticky
// once Count matches a non-zero Compare and is cleared by a Compare write.
module cp0_timer
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti,
    output logic        ti_set,
    output logic        ti_clr
);

    logic div;

    assign ti_clr = compare_we;
    assign ti_set = (count == compare) && (compare != 32'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= 32'd0;
            compare <= 32'd0;
            div     <= 1'b0;
            ti      <= 1'b0;
        end else begin
            if (count_we) begin
                count <= wdata;
                div   <= 1'b0;
            end else begin
                div <= ~div;
                if (div)
                    count <= count + 32'd1;
            end
            if (compare_we)
                compare <= wdata;
            // a Compare write always wins over a coincident match
            if (ti_clr)
                ti <= 1'b0;
            else if (ti_set)
                ti <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regs.sv
// Coprocessor-0 register bank: exception capture, eret, mtc0/mfc0,
// PC redirect pulse and interrupt request from the Count/Compare timer.
module cp0_regs
    import cp0_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR_BEV = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VECTOR       = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        except_in,
    input  logic [31:0] cause_in,
    input  logic [31:0] state_in,
    input  logic [31:0] badpc_in,
    input  logic [31:0] badaddr_in,
    input  logic        eret,
    input  logic        mtc0_we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        int_out,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc_out,
    output logic [31:0] status_out,
    output logic [31:0] cause_out
);

    logic [31:0] status, epc, badvaddr, count, compare;
    logic        bd, ti, ti_set, ti_clr;
    logic [4:0]  exc_code;
    logic [1:0]  ip_sw;
    logic        wr;
    logic        unused_ok;

    // mtc0 only lands when neither an exception nor eret claims the cycle
    assign wr = mtc0_we & ~except_in & ~eret;
    assign unused_ok = ^{cause_in[30:7], cause_in[1:0],
                         state_in[31:2], state_in[0],
                         ti_set, ti_clr};

    cp0_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (wr && cp0_addr == CP0_COUNT),
        .compare_we (wr && cp0_addr == CP0_COMPARE),
        .wdata      (wdata),
        .count      (count),
        .compare    (compare),
        .ti         (ti),
        .ti_set     (ti_set),
        .ti_clr     (ti_clr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            status      <= STATUS_RESET;
            epc         <= 32'd0;
            badvaddr    <= 32'd0;
            bd          <= 1'b0;
            exc_code    <= 5'd0;
            ip_sw       <= 2'd0;
            redirect    <= 1'b0;
            redirect_pc <= 32'd0;
        end else if (except_in) begin
            epc              <= badpc_in;
            bd               <= cause_in[CA_BD];
            exc_code         <= cause_in[CA_EXC_HI:CA_EXC_LO];
            status[ST_EXL]   <= 1'b1 | state_in[ST_EXL];
            if (is_addr_exc(cause_in[CA_EXC_HI:CA_EXC_LO]))
                badvaddr <= badaddr_in;
            redirect    <= 1'b1;
            redirect_pc <= status[ST_BEV] ? RESET_VECTOR_BEV : EXC_VECTOR;
        end else if (eret) begin
            status[ST_EXL] <= 1'b0;
            redirect       <= 1'b1;
            redirect_pc    <= epc;
        end else begin
            redirect <= 1'b0;
            if (wr) begin
                case (cp0_addr)
                    CP0_STATUS: status <= wdata & STATUS_WMASK;
                    CP0_CAUSE:  ip_sw  <= wdata[9:8];
                    CP0_EPC:    epc    <= wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign cause_out = {bd, ti, 14'd0, ti, 5'd0, ip_sw,
                        1'b0, exc_code, 2'd0};
    assign status_out = status;
    assign epc_out    = epc;

    assign int_out = status[ST_IE] & ~status[ST_EXL] &
                     |(cause_out[CA_IP_HI:CA_IP_LO] &
                       status[ST_IM_HI:ST_IM_LO]);

    always_comb begin
        rdata = 32'd0;
        case (cp0_addr)
            CP0_BADVADDR: rdata = badvaddr;
            CP0_COUNT:    rdata = count;
            CP0_COMPARE:  rdata = compare;
            CP0_STATUS:   rdata = status;
            CP0_CAUSE:    rdata = cause_out;
            CP0_EPC:      rdata = epc;
            default:      rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regs.sv
// Directed self-checking bench for the CP0 register bank.
module tb_cp0_regs;

    logic        clk = 1'b0;
    logic        rst;
    logic        except_in;
    logic [31:0] cause_in, state_in, badpc_in, badaddr_in;
    logic        eret, mtc0_we;
    logic [4:0]  cp0_addr;
    logic [31:0] wdata, rdata;
    logic        int_out, redirect;
    logic [31:0] redirect_pc, epc_out, status_out, cause_out;

    int total = 0;
    int bad   = 0;

    cp0_regs dut (
        .clk         (clk),
        .rst         (rst),
        .except_in   (except_in),
        .cause_in    (cause_in),
        .state_in    (state_in),
        .badpc_in    (badpc_in),
        .badaddr_in  (badaddr_in),
        .eret        (eret),
        .mtc0_we     (mtc0_we),
        .cp0_addr    (cp0_addr),
        .wdata       (wdata),
        .rdata       (rdata),
        .int_out     (int_out),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .epc_out     (epc_out),
        .status_out  (status_out),
        .cause_out   (cause_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cp0_addr = a;
        wdata    = d;
        mtc0_we  = 1'b1;
        tick();
        mtc0_we  = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        cp0_addr = a;
        #1;
        d = rdata;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        rd(5'd12, v);
        total++;
        if (v !== 32'h0040_0000) begin
            bad++;
            $display("FAIL reset_status got=%h exp=%h", v, 32'h0040_0000);
        end
        rd(5'd9, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL reset_count got=%h exp=0", v);
        end
        rd(5'd14, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL reset_epc got=%h exp=0", v);
        end
        total++;
        if (redirect !== 1'b0 || redirect_pc !== 32'd0) begin
            bad++;
            $display("FAIL reset_redirect got=%b/%h exp=0/0",
                     redirect, redirect_pc);
        end
    endtask

    task automatic test_exception_eret();
        logic [31:0] v;
        except_in  = 1'b1;
        cause_in   = 32'h8000_0010;
        badpc_in   = 32'h0040_0104;
        badaddr_in = 32'h0000_0003;
        tick();
        except_in  = 1'b0;
        total++;
        if (redirect !== 1'b1 || redirect_pc !== 32'hBFC0_0380) begin
            bad++;
            $display("FAIL exc_redirect got=%b/%h exp=1/bfc00380",
                     redirect, redirect_pc);
        end
        rd(5'd8, v);
        total++;
        if (epc_out !== 32'h0040_0104 || v !== 32'h3) begin
            bad++;
            $display("FAIL exc_epc_bad got=%h/%h exp=00400104/3",
                     epc_out, v);
        end
        total++;
        if (cause_out !== 32'h8000_0010 || status_out[1] !== 1'b1) begin
            bad++;
            $display("FAIL exc_cause_exl got=%h/%b exp=80000010/1",
                     cause_out, status_out[1]);
        end
        tick();
        total++;
        if (redirect !== 1'b0) begin
            bad++;
            $display("FAIL exc_pulse got=%b exp=0", redirect);
        end
        eret = 1'b1;
        tick();
        eret = 1'b0;
        total++;
        if (redirect !== 1'b1 || redirect_pc !== 32'h0040_0104 ||
            status_out !== 32'h0040_0000) begin
            bad++;
            $display("FAIL eret got=%b/%h/%h exp=1/00400104/00400000",
                     redirect, redirect_pc, status_out);
        end
        tick();
    endtask

    task automatic test_timer();
        logic [31:0] v;
        wr(5'd9, 32'd0);
        wr(5'd11, 32'd10);
        wr(5'd12, 32'h0000_8001);
        repeat (18) tick();
        rd(5'd9, v);
        total++;
        if (v !== 32'd10 || cause_out[30] !== 1'b0) begin
            bad++;
            $display("FAIL timer_match got=%0d/%b exp=10/0", v, cause_out[30]);
        end
        tick();
        total++;
        if (cause_out[30] !== 1'b1 || cause_out[15] !== 1'b1 ||
            int_out !== 1'b1) begin
            bad++;
            $display("FAIL timer_ti got=%b/%b/%b exp=1/1/1",
                     cause_out[30], cause_out[15], int_out);
        end
        wr(5'd11, 32'd50);
        total++;
        if (cause_out[30] !== 1'b0 || int_out !== 1'b0) begin
            bad++;
            $display("FAIL timer_clr got=%b/%b exp=0/0",
                     cause_out[30], int_out);
        end
    endtask

    task automatic test_priority();
        logic [31:0] v;
        except_in  = 1'b1;
        eret       = 1'b1;
        mtc0_we    = 1'b1;
        cp0_addr   = 5'd14;
        wdata      = 32'hDEAD_BEEF;
        cause_in   = 32'h0000_0030;
        badpc_in   = 32'h0040_0200;
        badaddr_in = 32'h0000_1234;
        tick();
        except_in  = 1'b0;
        eret       = 1'b0;
        mtc0_we    = 1'b0;
        total++;
        if (epc_out !== 32'h0040_0200 || redirect_pc !== 32'h8000_0180 ||
            redirect !== 1'b1) begin
            bad++;
            $display("FAIL prio_epc got=%h/%h/%b exp=00400200/80000180/1",
                     epc_out, redirect_pc, redirect);
        end
        rd(5'd8, v);
        total++;
        if (v !== 32'h3 || cause_out !== 32'h0000_0030 ||
            status_out !== 32'h0000_8003) begin
            bad++;
            $display("FAIL prio_regs got=%h/%h/%h exp=3/30/8003",
                     v, cause_out, status_out);
        end
    endtask

    task automatic test_back_to_back();
        except_in = 1'b1;
        cause_in  = 32'h0000_0020;
        badpc_in  = 32'h0000_1000;
        tick();
        badpc_in  = 32'h0000_2000;
        tick();
        except_in = 1'b0;
        total++;
        if (redirect !== 1'b1 || epc_out !== 32'h0000_2000) begin
            bad++;
            $display("FAIL b2b got=%b/%h exp=1/00002000", redirect, epc_out);
        end
        tick();
        total++;
        if (redirect !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end got=%b exp=0", redirect);
        end
    endtask

    task automatic test_masks_bypass();
        logic [31:0] v;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        wr(5'd12, 32'hFFFF_FFFF);
        wr(5'd13, 32'hFFFF_FFFF);
        total++;
        if (status_out !== 32'h0040_FF03 || cause_out !== 32'h0000_0320 ||
            int_out !== 1'b0) begin
            bad++;
            $display("FAIL masks got=%h/%h/%b exp=0040ff03/00000320/0",
                     status_out, cause_out, int_out);
        end
        wr(5'd12, 32'h0000_0301);
        total++;
        if (int_out !== 1'b1) begin
            bad++;
            $display("FAIL sw_int got=%b exp=1", int_out);
        end
        mtc0_we  = 1'b1;
        wdata    = 32'h1234_5678;
        rd(5'd14, v);
        total++;
        if (v !== 32'h0000_2000) begin
            bad++;
            $display("FAIL no_bypass got=%h exp=00002000", v);
        end
        tick();
        mtc0_we = 1'b0;
        rd(5'd14, v);
        total++;
        if (v !== 32'h1234_5678) begin
            bad++;
            $display("FAIL mtc0_vis got=%h exp=12345678", v);
        end
        wr(5'd5, 32'hFFFF_FFFF);
        rd(5'd5, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL unmapped got=%h exp=0", v);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        wr(5'd9, 32'hFFFF_FFFF);
        tick();
        rd(5'd9, v);
        total++;
        if (v !== 32'hFFFF_FFFF) begin
            bad++;
            $display("FAIL wrap_hold got=%h exp=ffffffff", v);
        end
        tick();
        rd(5'd9, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL wrap got=%h exp=0", v);
        end
    endtask

    task automatic test_reset_mid_redirect();
        logic [31:0] v;
        except_in  = 1'b1;
        cause_in   = 32'h0000_0014;
        badpc_in   = 32'h0040_0300;
        badaddr_in = 32'h0000_0777;
        tick();
        except_in  = 1'b0;
        total++;
        if (redirect !== 1'b1) begin
            bad++;
            $display("FAIL pre_rst got=%b exp=1", redirect);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rd(5'd8, v);
        total++;
        if (redirect !== 1'b0 || redirect_pc !== 32'd0 || v !== 32'd0 ||
            status_out !== 32'h0040_0000 || epc_out !== 32'd0 ||
            cause_out !== 32'd0) begin
            bad++;
            $display("FAIL rst_mid got=%b/%h/%h/%h/%h/%h exp=0/0/0/00400000/0/0",
                     redirect, redirect_pc, v, status_out, epc_out, cause_out);
        end
        rd(5'd9, v);
        total++;
        if (v !== 32'd0) begin
            bad++;
            $display("FAIL rst_count got=%h exp=0", v);
        end
    endtask

    initial begin
        rst        = 1'b1;
        except_in  = 1'b0;
        cause_in   = 32'd0;
        state_in   = 32'd0;
        badpc_in   = 32'd0;
        badaddr_in = 32'd0;
        eret       = 1'b0;
        mtc0_we    = 1'b0;
        cp0_addr   = 5'd0;
        wdata      = 32'd0;
        test_reset();
        test_exception_eret();
        test_timer();
        test_priority();
        test_back_to_back();
        test_masks_bypass();
        test_wrap();
        test_reset_mid_redirect();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
